// File: rtl/gshare_predictor.sv
// gshare_predictor: bimodal/gshare direction predictor with reset-time table init
// and a two-stage update pipeline fed by resolved branches.
module gshare_predictor #(
   parameter int PC_WIDTH   = 32,
   parameter int IDX_WIDTH  = 10,
   parameter int CTR_WIDTH  = 2,
   parameter int HIST_WIDTH = 8,
   parameter int MODE       = 1,
   parameter int INIT_CTR   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [PC_WIDTH-1:0]   pc,
   output logic                  pred_taken,
   output logic                  ready,
   input  logic                  upd_valid,
   input  logic [PC_WIDTH-1:0]   upd_pc,
   input  logic                  upd_is_br,
   input  logic                  upd_taken,
   output logic [HIST_WIDTH-1:0] ghr
);
   typedef enum logic {INIT, RUN} state_t;
   localparam logic [CTR_WIDTH-1:0] INIT_V = CTR_WIDTH'(INIT_CTR);
   state_t state, state_n;
   logic run, s_valid, s_is_br, s_taken, we, unused;
   logic [IDX_WIDTH-1:0] init_ptr, hist_x, idx, upd_idx, s_idx, w_idx;
   logic [CTR_WIDTH-1:0] mem [1 << IDX_WIDTH];
   logic [CTR_WIDTH-1:0] rd, wd;
   assign unused = ^{pc[PC_WIDTH-1:IDX_WIDTH+2], pc[1:0], upd_pc[PC_WIDTH-1:IDX_WIDTH+2], upd_pc[1:0]};
   assign run = state == RUN;
   assign ready = run;
   assign hist_x = (MODE != 0) ? IDX_WIDTH'(ghr) : '0;
   assign idx = pc[IDX_WIDTH+1:2] ^ hist_x;
   assign upd_idx = upd_pc[IDX_WIDTH+1:2] ^ hist_x;
   assign pred_taken = run & mem[idx][CTR_WIDTH-1];
   always_comb begin
      state_n = (state == INIT && &init_ptr) ? RUN : state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= INIT;
         init_ptr <= '0;
         ghr      <= '0;
         s_valid  <= 1'b0;
         s_idx    <= '0;
         s_is_br  <= 1'b0;
         s_taken  <= 1'b0;
      end else begin
         state   <= state_n;
         s_valid <= run & upd_valid;
         if (!run) init_ptr <= init_ptr + IDX_WIDTH'(1);
         if (run && upd_valid) begin
            s_idx   <= upd_idx;
            s_is_br <= upd_is_br;
            s_taken <= upd_taken;
            if (upd_is_br) ghr <= HIST_WIDTH'({ghr, upd_taken});
         end
      end
   end
   // Stage 2 reads the table as left by any previous write, so back-to-back updates accumulate.
   assign rd = mem[s_idx];
   assign wd = (!run || !s_is_br) ? INIT_V
             : s_taken ? (&rd ? rd : rd + CTR_WIDTH'(1))
             : (|rd ? rd - CTR_WIDTH'(1) : rd);
   assign w_idx = run ? s_idx : init_ptr;
   assign we = !run || s_valid;
   always_ff @(posedge clk) begin
      if (we) mem[w_idx] <= wd;
   end
endmodule
